// File: rtl/virtio_blk_pkg.sv
// virtio_blk_pkg
// Shared definitions for the VirtIO block storage backend:
//   - blk_store_state_t : request sequencer states
//   - BLOCK_SIZE        : bytes per block
//   - NUM_BLOCKS_DEFAULT: default count of valid blocks
//   - MEM_BASE_DEFAULT  : default byte address of block 0 in backing memory
//   - blk_words()       : backing-memory words per block
package virtio_blk_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DRAIN,
        RESP,
        RELEASE
    } blk_store_state_t;

    localparam int          BLOCK_SIZE         = 512;
    localparam int          NUM_BLOCKS_DEFAULT = 1024 * 1024;
    localparam logic [63:0] MEM_BASE_DEFAULT   = 64'h8800_0000;

    // Number of backing-memory words needed to move one block.
    function automatic int blk_words(input int block_size, input int data_width);
        return (block_size * 8) / data_width;
    endfunction

endpackage

// File: rtl/virtio_blk_storage_buf.sv
// virtio_blk_storage_buf
// One-block staging buffer of WORDS x DATA_WIDTH bits.
// Ports:
//   clk, rst_n    : clock, async active-low reset (buffer clears to zero)
//   i_load        : parallel load of the whole block from i_load_data
//   i_wr_en       : word write of i_wr_data at i_wr_idx (memory fetch path)
//   i_rd_idx      : word select for o_rd_data (memory drain path)
//   o_data        : full-width block contents, word 0 in the low bits
// A parallel load takes priority over a word write in the same cycle.
module virtio_blk_storage_buf #(
    parameter int WORDS      = virtio_blk_pkg::blk_words(virtio_blk_pkg::BLOCK_SIZE, 64),
    parameter int DATA_WIDTH = 64,
    parameter int IDX_W      = $clog2(WORDS)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        i_load,
    input  logic [WORDS*DATA_WIDTH-1:0] i_load_data,
    input  logic                        i_wr_en,
    input  logic [IDX_W-1:0]            i_wr_idx,
    input  logic [DATA_WIDTH-1:0]       i_wr_data,
    input  logic [IDX_W-1:0]            i_rd_idx,
    output logic [DATA_WIDTH-1:0]       o_rd_data,
    output logic [WORDS*DATA_WIDTH-1:0] o_data
);

    logic [WORDS-1:0][DATA_WIDTH-1:0] r_words;

    // Buffer storage: whole-block load or single-word update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_words <= '0;
        end else if (i_load) begin
            r_words <= i_load_data;
        end else if (i_wr_en) begin
            r_words[i_wr_idx] <= i_wr_data;
        end
    end

    assign o_rd_data = r_words[i_rd_idx];
    assign o_data    = r_words;

endmodule

// File: rtl/virtio_blk_storage.sv
// virtio_blk_storage
// Block-granular storage backend: serves one whole-block read or write at a
// time by moving the block as DATA_WIDTH-bit words over a backing-memory port,
// then pulses storage_ready (with storage_error) for one cycle.
// Ports:
//   clk, rst_n                : clock, async active-low reset
//   storage_block_addr        : block index of the request
//   storage_read/write        : level requests (read wins if both high)
//   storage_write_data        : write payload, word i in bits [64i+63:64i]
//   storage_read_data         : read payload (staging buffer output)
//   storage_ready/error       : one-cycle completion and its status
//   mem_addr/wdata/rdata      : backing-memory word address and data
//   mem_read/write/ready      : word request, held until mem_ready
// Build option: VIRTIO_BLK_STORAGE_RO_EN makes the device read-only; writes
// complete immediately with an error and the drain path is not built.
module virtio_blk_storage #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64,
    parameter int BLOCK_SIZE = virtio_blk_pkg::BLOCK_SIZE,
    parameter int NUM_BLOCKS = virtio_blk_pkg::NUM_BLOCKS_DEFAULT,
    parameter logic [ADDR_WIDTH-1:0] MEM_BASE = ADDR_WIDTH'(virtio_blk_pkg::MEM_BASE_DEFAULT)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [31:0]             storage_block_addr,
    input  logic [BLOCK_SIZE*8-1:0] storage_write_data,
    output logic [BLOCK_SIZE*8-1:0] storage_read_data,
    input  logic                    storage_read,
    input  logic                    storage_write,
    output logic                    storage_ready,
    output logic                    storage_error,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    input  logic [DATA_WIDTH-1:0]   mem_rdata,
    output logic                    mem_read,
    output logic                    mem_write,
    input  logic                    mem_ready
);

    import virtio_blk_pkg::*;

    localparam int              WORDS    = blk_words(BLOCK_SIZE, DATA_WIDTH);
    localparam int              IDX_W    = $clog2(WORDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    blk_store_state_t r_state;
    blk_store_state_t w_next;

    logic [31:0]       r_block;
    logic              r_error;
    logic [IDX_W-1:0]  r_idx;

    logic              w_range_err;
    logic              w_accept_rd;
    logic              w_accept_wr;
    logic              w_accept_err;
    logic              w_word_done;
    logic              w_buf_load;
    logic [BLOCK_SIZE*8-1:0] w_buf_load_data;
    logic [DATA_WIDTH-1:0]   w_buf_rd;
    logic [ADDR_WIDTH-1:0]   w_word_addr;

    assign w_range_err = (storage_block_addr >= 32'(NUM_BLOCKS));

    // Byte address of the current word; wraps silently in ADDR_WIDTH bits.
    assign w_word_addr = MEM_BASE
                       + ADDR_WIDTH'(r_block) * ADDR_WIDTH'(BLOCK_SIZE)
                       + ADDR_WIDTH'(r_idx) * ADDR_WIDTH'(DATA_WIDTH / 8);

    // State register plus the request context captured at accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_block <= '0;
            r_error <= 1'b0;
            r_idx   <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept_rd || w_accept_wr) begin
                r_block <= storage_block_addr;
                r_error <= w_accept_err;
                r_idx   <= '0;
            end else if (w_word_done) begin
                r_idx <= (r_idx == LAST_IDX) ? '0 : r_idx + 1'b1;
            end
        end
    end

    // Next state and all combinational outputs. Memory requests and the
    // completion pulse decode straight from the state register so that an
    // asynchronous reset drops them immediately.
    always_comb begin
        w_next        = r_state;
        w_accept_rd   = 1'b0;
        w_accept_wr   = 1'b0;
        w_accept_err  = 1'b0;
        storage_ready = 1'b0;
        storage_error = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_addr      = '0;
        mem_wdata     = '0;

        case (r_state)
            IDLE: begin
                if (storage_read) begin
                    w_accept_rd  = 1'b1;
                    w_accept_err = w_range_err;
                    w_next       = w_range_err ? RESP : FETCH;
                end else if (storage_write) begin
                    w_accept_wr  = 1'b1;
`ifdef VIRTIO_BLK_STORAGE_RO_EN
                    w_accept_err = 1'b1;
                    w_next       = RESP;
`else
                    w_accept_err = w_range_err;
                    w_next       = w_range_err ? RESP : DRAIN;
`endif
                end
            end
            FETCH: begin
                mem_read = 1'b1;
                mem_addr = w_word_addr;
                if (mem_ready && (r_idx == LAST_IDX)) begin
                    w_next = RESP;
                end
            end
`ifndef VIRTIO_BLK_STORAGE_RO_EN
            DRAIN: begin
                mem_write = 1'b1;
                mem_addr  = w_word_addr;
                mem_wdata = w_buf_rd;
                if (mem_ready && (r_idx == LAST_IDX)) begin
                    w_next = RESP;
                end
            end
`endif
            RESP: begin
                storage_ready = 1'b1;
                storage_error = r_error;
                w_next        = RELEASE;
            end
            RELEASE: begin
                // Wait for the initiator to drop its level request.
                if (!storage_read && !storage_write) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    assign w_word_done = (mem_read || mem_write) && mem_ready;

    // A rejected read clears the buffer so its payload reads as zeros; an
    // in-range write preloads the payload for draining.
`ifdef VIRTIO_BLK_STORAGE_RO_EN
    assign w_buf_load      = w_accept_rd && w_range_err;
    assign w_buf_load_data = '0;

    logic w_unused_ro;
    assign w_unused_ro = ^{storage_write_data, w_buf_rd};
`else
    assign w_buf_load      = (w_accept_rd && w_range_err)
                           || (w_accept_wr && !w_range_err);
    assign w_buf_load_data = w_accept_rd ? '0 : storage_write_data;
`endif

    virtio_blk_storage_buf #(
        .WORDS      (WORDS),
        .DATA_WIDTH (DATA_WIDTH),
        .IDX_W      (IDX_W)
    ) u_buf (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_load      (w_buf_load),
        .i_load_data (w_buf_load_data),
        .i_wr_en     (mem_read && mem_ready),
        .i_wr_idx    (r_idx),
        .i_wr_data   (mem_rdata),
        .i_rd_idx    (r_idx),
        .o_rd_data   (w_buf_rd),
        .o_data      (storage_read_data)
    );

endmodule

// File: tb/tb_virtio_blk_storage.sv
// tb_virtio_blk_storage
// Table-driven bench for virtio_blk_storage with a scoreboard: each applied
// request pushes its expected word transfers and completion into queues; a
// negedge monitor pops and compares them as the DUT produces them.
// Honours VIRTIO_BLK_STORAGE_RO_EN for the expected write outcomes.
module tb_virtio_blk_storage;

    localparam int          ADDR_WIDTH = 64;
    localparam int          BLOCK_SIZE = 512;
    localparam int          WORDS      = 64;
    localparam int          NUM_BLOCKS = 1024 * 1024;
    localparam logic [63:0] MEM_BASE   = 64'h8800_0000;
`ifdef VIRTIO_BLK_STORAGE_RO_EN
    localparam bit RO_BUILD = 1'b1;
`else
    localparam bit RO_BUILD = 1'b0;
`endif

    typedef struct {
        logic        isWrite;
        logic [63:0] addr;
        logic [63:0] data;
    } xfer_t;

    typedef struct {
        logic              isRead;
        logic              expErr;
        int                acceptCyc;
        int                expLat;
        logic [4095:0]     data;
    } resp_t;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] blk;
        logic        toggle;
        logic [63:0] salt;
        int          hold;
        logic        expErr;
        int          expLat;
    } vec_t;

    logic                  clk;
    logic                  rst_n;
    logic [31:0]           storage_block_addr;
    logic [4095:0]         storage_write_data;
    logic [4095:0]         storage_read_data;
    logic                  storage_read;
    logic                  storage_write;
    logic                  storage_ready;
    logic                  storage_error;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [63:0]           mem_wdata;
    logic [63:0]           mem_rdata;
    logic                  mem_read;
    logic                  mem_write;
    logic                  mem_ready;

    logic [63:0] rdSalt;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          completions = 0;
    int          xferCount = 0;
    xfer_t       memQ[$];
    resp_t       respQ[$];

    virtio_blk_storage dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .storage_block_addr (storage_block_addr),
        .storage_write_data (storage_write_data),
        .storage_read_data  (storage_read_data),
        .storage_read       (storage_read),
        .storage_write      (storage_write),
        .storage_ready      (storage_ready),
        .storage_error      (storage_error),
        .mem_addr           (mem_addr),
        .mem_wdata          (mem_wdata),
        .mem_rdata          (mem_rdata),
        .mem_read           (mem_read),
        .mem_write          (mem_write),
        .mem_ready          (mem_ready)
    );

    // Backing memory model: word k of any block returns salt | k.
    assign mem_rdata = rdSalt | {58'd0, mem_addr[8:3]};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: compares each completed word transfer and each completion
    // against the head of the matching scoreboard queue.
    always @(negedge clk) begin
        xfer_t x;
        resp_t r;
        int    bad;
        if (rst_n) begin
            if (mem_read || mem_write) begin
                checkOutput("memExclusive", 64'(mem_read && mem_write), 64'd0);
            end
            if ((mem_read || mem_write) && mem_ready) begin
                xferCount++;
                if (memQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpectedTransfer: got write=%0b addr=%h expected none", mem_write, mem_addr);
                end else begin
                    x = memQ.pop_front();
                    checkOutput("memAddr", mem_addr, x.addr);
                    checkOutput("memDir", 64'(mem_write), 64'(x.isWrite));
                    if (x.isWrite) checkOutput("memWdata", mem_wdata, x.data);
                end
            end
            if (storage_ready) begin
                completions++;
                if (respQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpectedCompletion: got ready=1 at cycle %0d expected none", cyc);
                end else begin
                    r = respQ.pop_front();
                    checkOutput("completionLatency", 64'(cyc - r.acceptCyc), 64'(r.expLat));
                    checkOutput("completionError", 64'(storage_error), 64'(r.expErr));
                    if (r.isRead) begin
                        bad = -1;
                        for (int k = WORDS - 1; k >= 0; k--) begin
                            if (storage_read_data[64*k +: 64] !== r.data[64*k +: 64]) bad = k;
                        end
                        checks++;
                        if (bad >= 0) begin
                            errors++;
                            $display("[TB] FAIL readData word %0d: got %h expected %h", bad,
                                     storage_read_data[64*bad +: 64], r.data[64*bad +: 64]);
                        end
                    end
                end
            end
        end
    end

    // Drives one request, queues its expected traffic, waits (bounded) for
    // the completion, optionally keeps the request up, then releases it.
    task automatic applyStimulus(input vec_t v);
        logic [4095:0] payload;
        xfer_t         x;
        resp_t         r;
        int            base;
        bit            done;
        base = completions;
        for (int k = 0; k < WORDS; k++) payload[64*k +: 64] = v.salt | 64'(k);
        storage_write_data = payload;
        rdSalt             = v.salt;
        storage_block_addr = v.blk;
        storage_read       = v.rd;
        storage_write      = v.wr;
        mem_ready          = 1'b1;
        r.isRead    = v.rd;
        r.expErr    = v.expErr;
        r.acceptCyc = cyc + 1;
        r.expLat    = v.expLat;
        r.data      = (v.rd && !v.expErr) ? payload : '0;
        respQ.push_back(r);
        if (!v.expErr) begin
            for (int k = 0; k < WORDS; k++) begin
                x.isWrite = !v.rd;
                x.addr    = MEM_BASE + 64'(v.blk) * 64'(BLOCK_SIZE) + 64'(k) * 64'd8;
                x.data    = payload[64*k +: 64];
                memQ.push_back(x);
            end
        end
        done = 1'b0;
        for (int c = 0; c < 400 && !done; c++) begin
            @(posedge clk);
            #1;
            if (completions != base) done = 1'b1;
            else if (v.toggle) mem_ready = ~mem_ready;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("[TB] FAIL completionTimeout: got no ready for block %0d expected one", v.blk);
            respQ.delete();
            memQ.delete();
        end
        repeat (v.hold) begin
            @(posedge clk);
            #1;
        end
        storage_read  = 1'b0;
        storage_write = 1'b0;
        mem_ready     = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        checkOutput("completionCount", 64'(completions - base), 64'd1);
        checkOutput("memQueueDrained", 64'(memQ.size()), 64'd0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got no end of test expected $finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t  vecs[8];
        vec_t  post;
        xfer_t x;
        int    base;
        int    baseX;
        bit    done;

        vecs[0] = '{1'b1, 1'b0, 32'd3, 1'b0, 64'h0, 0, 1'b0, 64};
        vecs[1] = '{1'b0, 1'b1, 32'd0, 1'b1, 64'hA5A5_0000_0000_0000, 0,
                    RO_BUILD ? 1'b1 : 1'b0, RO_BUILD ? 0 : 128};
        vecs[2] = '{1'b1, 1'b0, 32'(NUM_BLOCKS), 1'b0, 64'h0, 0, 1'b1, 0};
        vecs[3] = '{1'b1, 1'b0, 32'd2, 1'b0, 64'h1111_0000_0000_0000, 3, 1'b0, 64};
        vecs[4] = '{1'b1, 1'b1, 32'd5, 1'b0, 64'h2222_0000_0000_0000, 0, 1'b0, 64};
        vecs[5] = '{1'b0, 1'b1, 32'(NUM_BLOCKS + 7), 1'b0, 64'h0, 0, 1'b1, 0};
        vecs[6] = '{1'b1, 1'b0, 32'(NUM_BLOCKS - 1), 1'b1, 64'h3333_0000_0000_0000, 0, 1'b0, 128};
        vecs[7] = '{1'b0, 1'b1, 32'd1, 1'b0, 64'h4444_0000_0000_0000, 0,
                    RO_BUILD ? 1'b1 : 1'b0, RO_BUILD ? 0 : 64};
        post    = '{1'b1, 1'b0, 32'd9, 1'b0, 64'h6666_0000_0000_0000, 0, 1'b0, 64};

        rst_n              = 1'b0;
        storage_block_addr = '0;
        storage_write_data = '0;
        storage_read       = 1'b0;
        storage_write      = 1'b0;
        mem_ready          = 1'b1;
        rdSalt             = '0;
        #1;
        checkOutput("resetReady", 64'(storage_ready), 64'd0);
        checkOutput("resetError", 64'(storage_error), 64'd0);
        checkOutput("resetMemRead", 64'(mem_read), 64'd0);
        checkOutput("resetMemWrite", 64'(mem_write), 64'd0);
        checkOutput("resetMemAddr", mem_addr, 64'd0);
        checkOutput("resetMemWdata", mem_wdata, 64'd0);
        checkOutput("resetReadData", 64'(|storage_read_data), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 8; i++) begin
            $display("[TB] vector %0d: rd=%0b wr=%0b block=%0d", i, vecs[i].rd, vecs[i].wr, vecs[i].blk);
            applyStimulus(vecs[i]);
        end

        // Reset pulsed while word 20 of a read is outstanding.
        $display("[TB] reset during read transfer");
        base               = completions;
        baseX              = xferCount;
        storage_block_addr = 32'd7;
        rdSalt             = 64'h5555_0000_0000_0000;
        storage_read       = 1'b1;
        mem_ready          = 1'b1;
        for (int k = 0; k < 20; k++) begin
            x.isWrite = 1'b0;
            x.addr    = MEM_BASE + 64'd7 * 64'(BLOCK_SIZE) + 64'(k) * 64'd8;
            x.data    = '0;
            memQ.push_back(x);
        end
        done = 1'b0;
        for (int c = 0; c < 200 && !done; c++) begin
            @(posedge clk);
            #1;
            if (xferCount - baseX >= 20) done = 1'b1;
        end
        checkOutput("xferBeforeReset", 64'(xferCount - baseX), 64'd20);
        checkOutput("memReadBeforeReset", 64'(mem_read), 64'd1);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("memReadAsyncClear", 64'(mem_read), 64'd0);
        checkOutput("memAddrAsyncClear", mem_addr, 64'd0);
        checkOutput("readyAsyncClear", 64'(storage_ready), 64'd0);
        storage_read = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        checkOutput("noCompletionAfterReset", 64'(completions - base), 64'd0);
        checkOutput("memQueueAfterReset", 64'(memQ.size()), 64'd0);

        $display("[TB] read after reset");
        applyStimulus(post);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
